ysyx_220066_div: RTL and testbench



---
 rtl/ysyx_220066_div.sv | 266 ++++++++++++++++++++++++++
 tb/tb_ysyx_220066_div.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_220066_div.sv
// ----------------------------------------------------------------------------
// ysyx_220066_div
// Iterative radix-2 restoring divider for the RV64M divide/remainder family
// (DIV, DIVU, REM, REMU and their *W forms). It produces one quotient bit per
// cycle through trial subtraction. A valid/ready pair on each side decouples
// it from the execute stage.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   request valid
//   in_ready   request can be taken (high only while idle)
//   dividend   rs1 operand
//   divisor    rs2 operand
//   is_signed  1 = DIV/REM family, 0 = unsigned family
//   is_word    1 = *W variant, only bits [31:0] of each operand are used
//   is_rem     1 = return remainder, 0 = return quotient
//   flush      synchronous kill from a pipeline redirect (highest priority)
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   result     quotient or remainder; word results are sign-extended from bit 31
// ----------------------------------------------------------------------------
module ysyx_220066_div (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] dividend,
   input  logic [63:0] divisor,
   input  logic        is_signed,
   input  logic        is_word,
   input  logic        is_rem,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] result
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Sign-extend a 32-bit value to 64 bits.
   function automatic logic [63:0] sext32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   // Two's-complement negate when neg is set.
   function automatic logic [63:0] negate_if(input logic [63:0] v, input logic neg);
      logic [63:0] r;
      if (neg) begin
         r = ~v + 64'd1;
      end else begin
         r = v;
      end
      return r;
   endfunction

   state_t      state_r;
   logic [63:0] rem_r;
   logic [63:0] quo_r;
   logic [63:0] dvs_r;
   logic [6:0]  cnt_r;
   logic        sign_q_r;
   logic        sign_r_r;
   logic        is_word_r;
   logic        is_rem_r;
   logic        out_valid_r;
   logic [63:0] result_r;

   // request-side preprocessing
   logic [63:0] a_ext_s;
   logic [63:0] b_ext_s;
   logic        a_neg_s;
   logic        b_neg_s;
   logic [63:0] a_abs_s;
   logic [63:0] b_abs_s;
   logic [63:0] quo_init_s;
   logic        div_zero_s;
   logic        ovf_s;
   logic [63:0] special_raw_s;
   logic [63:0] special_res_s;

   // iteration and fix-up
   logic [64:0] rem_sh_s;
   logic [63:0] diff_s;
   logic        borrow_s;
   logic [63:0] rem_nx_s;
   logic [63:0] quo_nx_s;
   logic [63:0] q_raw_s;
   logic [63:0] q_fix_s;
   logic [63:0] r_fix_s;
   logic [63:0] sel_s;
   logic [63:0] final_res_s;
   logic        last_iter_s;

   assign in_ready  = (state_r == IDLE);
   assign out_valid = out_valid_r;
   assign result    = result_r;

   // Operand extension, absolute values and special-case detection for a new request.
   always_comb begin
      a_ext_s       = dividend;
      b_ext_s       = divisor;
      special_raw_s = 64'd0;
      if (is_word) begin
         if (is_signed) begin
            a_ext_s = sext32(dividend[31:0]);
            b_ext_s = sext32(divisor[31:0]);
         end else begin
            a_ext_s = {32'd0, dividend[31:0]};
            b_ext_s = {32'd0, divisor[31:0]};
         end
      end else begin
         a_ext_s = dividend;
         b_ext_s = divisor;
      end

      a_neg_s = is_signed & a_ext_s[63];
      b_neg_s = is_signed & b_ext_s[63];
      a_abs_s = negate_if(a_ext_s, a_neg_s);
      b_abs_s = negate_if(b_ext_s, b_neg_s);

      // Word dividends start in the top half so that 32 shifts leave the
      // quotient in quo[31:0] and the remainder in rem.
      if (is_word) begin
         quo_init_s = {a_abs_s[31:0], 32'd0};
      end else begin
         quo_init_s = a_abs_s;
      end

      div_zero_s = (b_ext_s == 64'd0);
      // Word operands are already sign-extended, so the most negative word
      // value appears here as 0xFFFF_FFFF_8000_0000.
      ovf_s = is_signed
            & (a_ext_s == (is_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000))
            & (b_ext_s == 64'hFFFF_FFFF_FFFF_FFFF);

      if (div_zero_s) begin
         special_raw_s = is_rem ? a_ext_s : 64'hFFFF_FFFF_FFFF_FFFF;
      end else if (ovf_s) begin
         special_raw_s = is_rem ? 64'd0 : a_ext_s;
      end else begin
         special_raw_s = 64'd0;
      end

      if (is_word) begin
         special_res_s = sext32(special_raw_s[31:0]);
      end else begin
         special_res_s = special_raw_s;
      end
   end

   // One restoring step plus the sign fix-up applied to the post-step values.
   always_comb begin
      rem_sh_s = {rem_r, quo_r[63]};
      borrow_s = (rem_sh_s < {1'b0, dvs_r});
      // The true difference is below 2^64 whenever it is kept, so modulo-2^64
      // arithmetic is enough.
      diff_s   = rem_sh_s[63:0] - dvs_r;
      if (borrow_s) begin
         rem_nx_s = rem_sh_s[63:0];
      end else begin
         rem_nx_s = diff_s;
      end
      quo_nx_s = {quo_r[62:0], ~borrow_s};

      if (is_word_r) begin
         q_raw_s = {32'd0, quo_nx_s[31:0]};
      end else begin
         q_raw_s = quo_nx_s;
      end
      q_fix_s = negate_if(q_raw_s, sign_q_r);
      r_fix_s = negate_if(rem_nx_s, sign_r_r);
      if (is_rem_r) begin
         sel_s = r_fix_s;
      end else begin
         sel_s = q_fix_s;
      end
      if (is_word_r) begin
         final_res_s = sext32(sel_s[31:0]);
      end else begin
         final_res_s = sel_s;
      end

      last_iter_s = (cnt_r == (is_word_r ? 7'd31 : 7'd63));
   end

   // Control FSM with registered datapath and outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         rem_r       <= 64'd0;
         quo_r       <= 64'd0;
         dvs_r       <= 64'd0;
         cnt_r       <= 7'd0;
         sign_q_r    <= 1'b0;
         sign_r_r    <= 1'b0;
         is_word_r   <= 1'b0;
         is_rem_r    <= 1'b0;
         out_valid_r <= 1'b0;
         result_r    <= 64'd0;
      end else if (flush) begin
         state_r     <= IDLE;
         out_valid_r <= 1'b0;
         cnt_r       <= 7'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  is_word_r <= is_word;
                  is_rem_r  <= is_rem;
                  sign_q_r  <= a_neg_s ^ b_neg_s;
                  sign_r_r  <= a_neg_s;
                  cnt_r     <= 7'd0;
                  rem_r     <= 64'd0;
                  quo_r     <= quo_init_s;
                  dvs_r     <= b_abs_s;
                  if (div_zero_s || ovf_s) begin
                     // Answer is known now; out_valid is raised on the
                     // following edge from DONE.
                     state_r  <= DONE;
                     result_r <= special_res_s;
                  end else begin
                     state_r <= CALC;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            CALC: begin
               rem_r <= rem_nx_s;
               quo_r <= quo_nx_s;
               if (last_iter_s) begin
                  state_r     <= DONE;
                  cnt_r       <= 7'd0;
                  result_r    <= final_res_s;
                  out_valid_r <= 1'b1;
               end else begin
                  state_r <= CALC;
                  cnt_r   <= cnt_r + 7'd1;
               end
            end
            DONE: begin
               if (!out_valid_r) begin
                  // First DONE cycle after a special-case request.
                  out_valid_r <= 1'b1;
               end else if (out_ready) begin
                  out_valid_r <= 1'b0;
                  state_r     <= IDLE;
               end else begin
                  state_r <= DONE;
               end
            end
            default: begin
               state_r     <= IDLE;
               out_valid_r <= 1'b0;
               cnt_r       <= 7'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_220066_div.sv
module tb_ysyx_220066_div;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] dividend;
   logic [63:0] divisor;
   logic        is_signed;
   logic        is_word;
   logic        is_rem;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] result;

   ysyx_220066_div dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .is_signed (is_signed),
      .is_word   (is_word),
      .is_rem    (is_rem),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   // clock
   always #5 clk = ~clk;

   int cyc = 0;
   // cycle counter used for latency measurement
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] exp_v;
      int          acc;
      int          lat;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_checks++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: actual=%h required=%h", name, act, exp_v);
   endtask

   // monitor: pop the scoreboard on every accepted result
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_out: actual result=%h required=no output", result);
         end else begin
            e = sb_q.pop_front();
            chk(e.name, result, e.exp_v);
            if (e.lat >= 0) chk({e.name, "_lat"}, 64'(cyc - e.acc), 64'(e.lat));
         end
      end
   end

   task automatic send(input string name, input logic [63:0] a, input logic [63:0] b,
                       input logic s, input logic w, input logic r,
                       input logic [63:0] exp_v, input int lat, input bit push);
      int i;
      i = 0;
      @(negedge clk);
      while (!in_ready && i < 300) begin
         @(negedge clk);
         i++;
      end
      if (!in_ready) begin
         n_checks++;
         $display("FAIL %s_accept: actual in_ready=0 required=1", name);
      end else begin
         dividend  = a;
         divisor   = b;
         is_signed = s;
         is_word   = w;
         is_rem    = r;
         in_valid  = 1'b1;
         if (push) sb_q.push_back('{exp_v, cyc + 1, lat, name});
         @(posedge clk);
         #1 in_valid = 1'b0;
      end
   endtask

   task automatic drain(input string name);
      int i;
      i = 0;
      while (sb_q.size() != 0 && i < 300) begin
         @(negedge clk);
         i++;
      end
      if (sb_q.size() != 0) begin
         n_checks++;
         $display("FAIL %s_timeout: actual pending=%0d required=0", name, sb_q.size());
         sb_q.delete();
      end
   endtask

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // stimulus
   initial begin
      int i;
      rst_n = 1'b0; in_valid = 1'b0; dividend = 64'd0; divisor = 64'd0;
      is_signed = 1'b0; is_word = 1'b0; is_rem = 1'b0; flush = 1'b0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_result", result, 64'd0);
      rst_n = 1'b1;

      send("div_m7_2",     64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64, 1'b1);
      send("rem_m7_2",     64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b1);
      send("divuw_hi",     64'h0000_0001_8000_0000, 64'd1, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_8000_0000, 32, 1'b1);
      send("remuw_100_7",  64'd100, 64'd7, 1'b0, 1'b1, 1'b1, 64'd2, 32, 1'b1);
      send("divu_by0",     64'd5, 64'd0, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b1);
      send("remw_by0",     64'h1234_5678_8000_0001, 64'd0, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0001, 1, 1'b1);
      send("div_ovf",      64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1, 1'b1);
      send("rem_ovf",      64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 64'd0, 1, 1'b1);
      send("divw_ovf",     64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_8000_0000, 1, 1'b1);
      send("rem_7_m2",     64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b1, 64'd1, 64, 1'b1);
      send("div_m100_m7",  64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 1'b0, 1'b0, 64'd14, 64, 1'b1);
      send("divw_garbage", 64'hDEAD_BEEF_FFFF_FFF9, 64'h1234_5678_0000_0002, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 32, 1'b1);
      send("remu_big",     64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 1'b0, 1'b0, 1'b1, 64'hF, 64, 1'b1);
      drain("vectors");

      // backpressure hold
      @(posedge clk);
      #1 out_ready = 1'b0;
      send("hs_divu", 64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 64'd14, -1, 1'b1);
      i = 0;
      while (!out_valid && i < 200) begin
         @(negedge clk);
         i++;
      end
      if (!out_valid) begin
         n_checks++;
         $display("FAIL hs_wait_valid: actual out_valid=0 required=1");
      end
      for (int k = 0; k < 10; k++) begin
         chk("hs_hold_result", result, 64'd14);
         chk("hs_hold_in_ready", {63'd0, in_ready}, 64'd0);
         chk("hs_hold_valid", {63'd0, out_valid}, 64'd1);
         @(negedge clk);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      chk("hs_valid_drop", {63'd0, out_valid}, 64'd0);
      chk("hs_ready_rise", {63'd0, in_ready}, 64'd1);
      out_ready = 1'b1;
      drain("handshake");

      // flush during CALC at iteration 20
      send("fl_dummy", 64'd1000, 64'd3, 1'b1, 1'b0, 1'b0, 64'd0, 0, 1'b0);
      repeat (19) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      chk("fl_in_ready", {63'd0, in_ready}, 64'd1);
      chk("fl_out_valid", {63'd0, out_valid}, 64'd0);
      send("fl_after", 64'hFFFF_FFFF_FFFF_FC18, 64'd3, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FEB3, 64, 1'b1);
      drain("flush");

      // flush in IDLE blocks a request
      @(negedge clk);
      dividend = 64'd5; divisor = 64'd0; is_signed = 1'b0; is_word = 1'b0; is_rem = 1'b0;
      in_valid = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("fl_idle_ready", {63'd0, in_ready}, 64'd1);
      repeat (3) @(negedge clk);
      chk("fl_idle_no_valid", {63'd0, out_valid}, 64'd0);

      // reset mid-CALC
      send("rst_dummy", 64'd1000, 64'd3, 1'b1, 1'b0, 1'b0, 64'd0, 0, 1'b0);
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_mid_result", result, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (80) @(negedge clk);
      chk("rst_no_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_idle", {63'd0, in_ready}, 64'd1);
      drain("final");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
